// File: rtl/canny_frame_scheduler.sv
// Frame sequencer for the canny pipeline: latches frame size, issues the control packet,
// gates upstream reads and pipeline advance, drains the pipeline and reports length errors.
module canny_frame_scheduler #(
  parameter int PIPE_LATENCY = 1287,
  parameter int DIM_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vip_ctrl_valid,
  input  logic [DIM_W-1:0] width_in,
  input  logic [DIM_W-1:0] height_in,
  input  logic             vip_ctrl_busy,
  output logic             vip_ctrl_send,
  output logic [DIM_W-1:0] width_out,
  output logic [DIM_W-1:0] height_out,
  input  logic             stall_in,
  input  logic             end_of_video,
  input  logic             stall_out,
  output logic             read,
  output logic             pipe_en,
  output logic             inject_flush,
  output logic             out_write,
  output logic             out_eop,
  output logic [DIM_W-1:0] x_cnt,
  output logic [DIM_W-1:0] y_cnt,
  output logic [15:0]      frame_cnt,
  output logic             frame_done,
  output logic             err_short,
  output logic             err_long,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CTRL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      cur_state, nxt_state;
  logic [31:0] npix, target, in_total, out_total;
  logic        accept, last_pix;

  assign state = cur_state;

  // IDLE keeps reading so stale upstream beats are flushed away between frames
  assign read     = ~rst & ((cur_state == IDLE) | ((cur_state == RUN) & ~stall_out));
  assign accept   = read & ~stall_in;
  assign last_pix = (x_cnt == width_out - DIM_W'(1)) && (y_cnt == height_out - DIM_W'(1));

  always_comb begin
    nxt_state     = cur_state;
    pipe_en       = 1'b0;
    inject_flush  = 1'b0;
    out_write     = 1'b0;
    out_eop       = 1'b0;
    vip_ctrl_send = 1'b0;
    case (cur_state)
      IDLE: begin
        if (vip_ctrl_valid && (width_in != '0) && (height_in != '0)) nxt_state = CTRL;
      end
      CTRL: begin
        if (!vip_ctrl_busy) begin
          vip_ctrl_send = 1'b1;
          nxt_state     = RUN;
        end
      end
      RUN: begin
        pipe_en   = accept;
        out_write = accept && (in_total >= 32'(PIPE_LATENCY));
        if (accept && (last_pix || end_of_video)) nxt_state = DRAIN;
      end
      DRAIN: begin
        inject_flush = 1'b1;
        pipe_en      = !stall_out && (out_total < target);
        out_write    = pipe_en;
      end
      default: nxt_state = IDLE;
    endcase
    // The final output beat ends the frame whichever state it lands in
    out_eop = out_write && (out_total == target - 32'd1);
    if (out_eop) nxt_state = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state  <= IDLE;
      width_out  <= DIM_W'(640);
      height_out <= DIM_W'(480);
      npix       <= '0;
      target     <= '0;
      in_total   <= '0;
      out_total  <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      case (cur_state)
        IDLE: begin
          if (nxt_state == CTRL) begin
            width_out  <= width_in;
            height_out <= height_in;
            npix       <= 32'(width_in) * 32'(height_in);
          end
        end
        CTRL: begin
          if (vip_ctrl_send) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            in_total  <= '0;
            out_total <= '0;
            target    <= npix;
          end
        end
        RUN: begin
          if (accept) begin
            in_total <= in_total + 32'd1;
            if (x_cnt == width_out - DIM_W'(1)) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + DIM_W'(1);
            end else begin
              x_cnt <= x_cnt + DIM_W'(1);
            end
            // A short frame drains only the pixels that actually went in
            if (last_pix) begin
              err_long <= ~end_of_video;
            end else if (end_of_video) begin
              err_short <= 1'b1;
              target    <= in_total + 32'd1;
            end
          end
        end
        default: ;
      endcase
      if (out_write) out_total <= out_total + 32'd1;
      if (out_eop) begin
        frame_done <= 1'b1;
        frame_cnt  <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_canny_frame_scheduler.sv
// Directed bench for canny_frame_scheduler with a short pipeline latency of 5.
module tb_canny_frame_scheduler;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vip_ctrl_valid = 1'b0;
  logic [15:0] width_in = '0;
  logic [15:0] height_in = '0;
  logic        vip_ctrl_busy = 1'b0;
  logic        vip_ctrl_send;
  logic [15:0] width_out, height_out;
  logic        stall_in = 1'b1;
  logic        end_of_video = 1'b0;
  logic        stall_out = 1'b0;
  logic        read, pipe_en, inject_flush, out_write, out_eop;
  logic [15:0] x_cnt, y_cnt, frame_cnt;
  logic        frame_done, err_short, err_long;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  int wr, rwr, eop_at, eop_cnt, gap, shorts, longs, sbad, fbad;
  bit tmo;
  int sends, scyc;
  bit stmo;

  always #5 clk = ~clk;

  canny_frame_scheduler #(.PIPE_LATENCY(LAT), .DIM_W(16)) dut (
    .clk(clk), .rst(rst),
    .vip_ctrl_valid(vip_ctrl_valid), .width_in(width_in), .height_in(height_in),
    .vip_ctrl_busy(vip_ctrl_busy), .vip_ctrl_send(vip_ctrl_send),
    .width_out(width_out), .height_out(height_out),
    .stall_in(stall_in), .end_of_video(end_of_video), .stall_out(stall_out),
    .read(read), .pipe_en(pipe_en), .inject_flush(inject_flush),
    .out_write(out_write), .out_eop(out_eop),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_cnt(frame_cnt), .frame_done(frame_done),
    .err_short(err_short), .err_long(err_long), .state(state)
  );

  // Presents a control packet in IDLE, then counts CTRL cycles until RUN is reached
  task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input int busy_cycles,
                           output int n_send, output int send_cyc, output bit timed_out);
    n_send = 0; send_cyc = 0; timed_out = 1'b1;
    vip_ctrl_valid = 1'b1; width_in = w; height_in = h; vip_ctrl_busy = 1'b1;
    @(posedge clk); #1;
    vip_ctrl_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      vip_ctrl_busy = (k <= busy_cycles);
      #1;
      if (vip_ctrl_send) begin n_send++; send_cyc = k; end
      @(posedge clk); #1;
      if (state == 2'd2) begin timed_out = 1'b0; break; end
    end
    vip_ctrl_busy = 1'b0;
  endtask

  // Streams pixels from RUN until the frame_done cycle (or until drain cycle abort_at)
  task automatic run_frame(input int n_in, input int eov_idx, input int stall_at, input int stall_len,
                           input int abort_at,
                           output int writes, output int run_writes, output int eop_w, output int eops,
                           output int done_gap, output int n_short, output int n_long,
                           output int stall_bad, output int flush_bad, output bit timed_out);
    int sent, drain_idx, eop_cyc;
    bit done;
    sent = 0; drain_idx = 0; eop_cyc = -100; done = 1'b0;
    writes = 0; run_writes = 0; eop_w = 0; eops = 0; done_gap = -1;
    n_short = 0; n_long = 0; stall_bad = 0; flush_bad = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (state == 2'd3) drain_idx++;
      if (abort_at != 0 && drain_idx == abort_at) break;
      stall_in     = (sent >= n_in);
      end_of_video = (sent + 1 == eov_idx);
      stall_out    = (state == 2'd3) && (stall_at != 0) &&
                     (drain_idx >= stall_at) && (drain_idx < stall_at + stall_len);
      #1;
      if (frame_done) begin done = 1'b1; done_gap = cyc - eop_cyc; end
      if (err_short) n_short++;
      if (err_long) n_long++;
      if (read && !stall_in) sent++;
      if (stall_out && (pipe_en || out_write || read)) stall_bad++;
      if (state == 2'd3 && !inject_flush) flush_bad++;
      if (out_write) begin
        writes++;
        if (state == 2'd2) run_writes++;
        if (out_eop) begin eops++; eop_w = writes; eop_cyc = cyc; end
      end
      @(posedge clk); #1;
    end
    stall_in = 1'b1; end_of_video = 1'b0; stall_out = 1'b0;
    timed_out = !done && (abort_at == 0);
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d, expected 0", state); end
    checks++; if (width_out !== 16'd640) begin errors++; $display("[TB] FAIL reset_width: got %0d, expected 640", width_out); end
    checks++; if (height_out !== 16'd480) begin errors++; $display("[TB] FAIL reset_height: got %0d, expected 480", height_out); end
    checks++; if ({read, pipe_en, out_write, vip_ctrl_send} !== 4'b0) begin errors++; $display("[TB] FAIL reset_strobes: got %b, expected 0000", {read, pipe_en, out_write, vip_ctrl_send}); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (read !== 1'b1) begin errors++; $display("[TB] FAIL idle_read: got %0d, expected 1", read); end
  endtask

  task automatic test_normal_frame();
    send_ctrl(16'd4, 16'd3, 0, sends, scyc, stmo);
    checks++; if (stmo || sends !== 1) begin errors++; $display("[TB] FAIL normal_send: got %0d sends (timeout %0d), expected 1", sends, stmo); end
    checks++; if (width_out !== 16'd4 || height_out !== 16'd3) begin errors++; $display("[TB] FAIL normal_dims: got %0dx%0d, expected 4x3", width_out, height_out); end
    run_frame(12, 12, 0, 0, 0, wr, rwr, eop_at, eop_cnt, gap, shorts, longs, sbad, fbad, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL normal_timeout: got no frame_done, expected frame_done"); end
    checks++; if (wr !== 12) begin errors++; $display("[TB] FAIL normal_writes: got %0d, expected 12", wr); end
    checks++; if (rwr !== 7) begin errors++; $display("[TB] FAIL normal_run_writes: got %0d, expected 7", rwr); end
    checks++; if (eop_cnt !== 1 || eop_at !== 12) begin errors++; $display("[TB] FAIL normal_eop: got %0d eops at write %0d, expected 1 at 12", eop_cnt, eop_at); end
    checks++; if (gap !== 1) begin errors++; $display("[TB] FAIL normal_done_gap: got %0d, expected 1", gap); end
    checks++; if (shorts !== 0 || longs !== 0) begin errors++; $display("[TB] FAIL normal_errs: got short %0d long %0d, expected 0 0", shorts, longs); end
    checks++; if (fbad !== 0) begin errors++; $display("[TB] FAIL normal_flush: got %0d drain cycles without flush, expected 0", fbad); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL normal_frame_cnt: got %0d, expected 1", frame_cnt); end
    checks++; if (frame_done !== 1'b0 || state !== 2'd0) begin errors++; $display("[TB] FAIL normal_after: got done %0d state %0d, expected 0 0", frame_done, state); end
    checks++; if (x_cnt !== 16'd0 || y_cnt !== 16'd3) begin errors++; $display("[TB] FAIL normal_xy: got %0d,%0d, expected 0,3", x_cnt, y_cnt); end
  endtask

  task automatic test_drain_stall();
    send_ctrl(16'd4, 16'd3, 0, sends, scyc, stmo);
    run_frame(12, 12, 2, 3, 0, wr, rwr, eop_at, eop_cnt, gap, shorts, longs, sbad, fbad, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL stall_timeout: got no frame_done, expected frame_done"); end
    checks++; if (sbad !== 0) begin errors++; $display("[TB] FAIL stall_gating: got %0d active stalled cycles, expected 0", sbad); end
    checks++; if (wr !== 12 || eop_at !== 12) begin errors++; $display("[TB] FAIL stall_writes: got %0d writes eop at %0d, expected 12 and 12", wr, eop_at); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL stall_frame_cnt: got %0d, expected 2", frame_cnt); end
  endtask

  task automatic test_early_eov();
    send_ctrl(16'd4, 16'd3, 0, sends, scyc, stmo);
    run_frame(8, 8, 0, 0, 0, wr, rwr, eop_at, eop_cnt, gap, shorts, longs, sbad, fbad, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL short_timeout: got no frame_done, expected frame_done"); end
    checks++; if (shorts !== 1 || longs !== 0) begin errors++; $display("[TB] FAIL short_errs: got short %0d long %0d, expected 1 0", shorts, longs); end
    checks++; if (rwr !== 3 || wr !== 8) begin errors++; $display("[TB] FAIL short_writes: got run %0d total %0d, expected 3 and 8", rwr, wr); end
    checks++; if (eop_at !== 8 || gap !== 1) begin errors++; $display("[TB] FAIL short_eop: got eop at %0d gap %0d, expected 8 and 1", eop_at, gap); end
    checks++; if (x_cnt !== 16'd0 || y_cnt !== 16'd2) begin errors++; $display("[TB] FAIL short_xy: got %0d,%0d, expected 0,2", x_cnt, y_cnt); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("[TB] FAIL short_frame_cnt: got %0d, expected 3", frame_cnt); end
  endtask

  task automatic test_long_frame();
    int acc, bad;
    acc = 0; bad = 0;
    send_ctrl(16'd4, 16'd3, 0, sends, scyc, stmo);
    run_frame(12, 0, 0, 0, 0, wr, rwr, eop_at, eop_cnt, gap, shorts, longs, sbad, fbad, tmo);
    checks++; if (longs !== 1 || shorts !== 0) begin errors++; $display("[TB] FAIL long_errs: got short %0d long %0d, expected 0 1", shorts, longs); end
    checks++; if (wr !== 12 || eop_at !== 12) begin errors++; $display("[TB] FAIL long_writes: got %0d writes eop at %0d, expected 12 and 12", wr, eop_at); end
    for (int k = 0; k < 2; k++) begin
      stall_in = 1'b0;
      #1;
      if (read && !stall_in) acc++;
      if (pipe_en || out_write) bad++;
      @(posedge clk); #1;
    end
    stall_in = 1'b1;
    checks++; if (acc !== 2 || bad !== 0) begin errors++; $display("[TB] FAIL idle_discard: got %0d reads %0d advances, expected 2 and 0", acc, bad); end
    checks++; if (state !== 2'd0 || x_cnt !== 16'd0) begin errors++; $display("[TB] FAIL idle_hold: got state %0d x %0d, expected 0 0", state, x_cnt); end
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("[TB] FAIL long_frame_cnt: got %0d, expected 4", frame_cnt); end
  endtask

  task automatic test_ctrl_packet();
    int bad;
    bad = 0;
    vip_ctrl_valid = 1'b1; width_in = 16'd0; height_in = 16'd3;
    @(posedge clk); #1;
    vip_ctrl_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (state !== 2'd0 || vip_ctrl_send) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL zero_dim: got %0d non-idle cycles, expected 0", bad); end
    checks++; if (width_out !== 16'd4) begin errors++; $display("[TB] FAIL zero_dim_width: got %0d, expected 4", width_out); end
    send_ctrl(16'd4, 16'd3, 4, sends, scyc, stmo);
    checks++; if (stmo || sends !== 1 || scyc !== 5) begin errors++; $display("[TB] FAIL busy_send: got %0d sends at cycle %0d, expected 1 at 5", sends, scyc); end
    run_frame(12, 12, 0, 0, 0, wr, rwr, eop_at, eop_cnt, gap, shorts, longs, sbad, fbad, tmo);
    checks++; if (wr !== 12 || frame_cnt !== 16'd5) begin errors++; $display("[TB] FAIL busy_frame: got %0d writes frame_cnt %0d, expected 12 and 5", wr, frame_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    int eops_after;
    eops_after = 0;
    send_ctrl(16'd3, 16'd2, 0, sends, scyc, stmo);
    run_frame(6, 6, 0, 0, 2, wr, rwr, eop_at, eop_cnt, gap, shorts, longs, sbad, fbad, tmo);
    checks++; if (state !== 2'd3) begin errors++; $display("[TB] FAIL abort_in_drain: got state %0d, expected 3", state); end
    rst = 1'b1;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("[TB] FAIL abort_state: got %0d, expected 0", state); end
    checks++; if (width_out !== 16'd640 || height_out !== 16'd480) begin errors++; $display("[TB] FAIL abort_dims: got %0dx%0d, expected 640x480", width_out, height_out); end
    checks++; if ({read, pipe_en, inject_flush, out_write, out_eop} !== 5'b0) begin errors++; $display("[TB] FAIL abort_strobes: got %b, expected 00000", {read, pipe_en, inject_flush, out_write, out_eop}); end
    checks++; if (frame_cnt !== 16'd0 || x_cnt !== 16'd0 || y_cnt !== 16'd0) begin errors++; $display("[TB] FAIL abort_counters: got frame %0d x %0d y %0d, expected 0 0 0", frame_cnt, x_cnt, y_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (out_eop || frame_done || state !== 2'd0) eops_after++;
      @(posedge clk); #1;
    end
    checks++; if (eops_after !== 0) begin errors++; $display("[TB] FAIL abort_quiet: got %0d active cycles, expected 0", eops_after); end
  endtask

  initial begin
    $display("[TB] start, PIPE_LATENCY=%0d", LAT);
    test_reset();
    test_normal_frame();
    test_drain_stall();
    test_early_eov();
    test_long_frame();
    test_ctrl_packet();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
